// File: rtl/div.sv
// Sequential signed 32-bit divider: 32-iteration restoring division on operand
// magnitudes, quotient to lo and remainder to hi, with a one-cycle div_stop pulse.
module div (
  input  logic        clk,
  input  logic        reset,
  input  logic        div_control,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_stop,
  output logic        div_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  // The stored remainder is always below |B|, so 32 bits hold it; only the
  // shifted working value needs the 33rd bit.
  logic [31:0] r_rem;
  logic [31:0] r_dq;
  logic [31:0] r_dvs;
  logic [5:0]  r_cnt;
  logic        r_sign_q;
  logic        r_sign_r;

  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic        w_b_zero;
  logic [32:0] w_rem_sh;
  logic        w_ge;
  logic [32:0] w_rem_sub;
  logic [31:0] w_rem_nxt;
  logic [31:0] w_dq_nxt;
  logic        w_load;
  logic        w_iter;
  logic        w_finish;
  logic        w_zero_path;

  assign w_a_mag  = A[31] ? (32'd0 - A) : A;
  assign w_b_mag  = B[31] ? (32'd0 - B) : B;
  assign w_b_zero = (B == 32'd0);

  assign w_rem_sh  = {r_rem, r_dq[31]};
  assign w_ge      = (w_rem_sh >= {1'b0, r_dvs});
  assign w_rem_sub = w_rem_sh - {1'b0, r_dvs};
  assign w_rem_nxt = w_ge ? w_rem_sub[31:0] : w_rem_sh[31:0];
  assign w_dq_nxt  = {r_dq[30:0], w_ge};

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_iter      = 1'b0;
    w_finish    = 1'b0;
    w_zero_path = 1'b0;
    case (r_state)
      IDLE: begin
        if (div_control) begin
          if (w_b_zero) begin
            w_zero_path = 1'b1;
            w_state_nxt = DONE;
          end else begin
            w_load      = 1'b1;
            w_state_nxt = RUN;
          end
        end
      end
      RUN: begin
        w_iter = 1'b1;
        if (r_cnt == 6'd31) begin
          w_finish    = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rem    <= 32'd0;
      r_dq     <= 32'd0;
      r_dvs    <= 32'd0;
      r_cnt    <= 6'd0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
    end else if (w_load) begin
      r_rem    <= 32'd0;
      r_dq     <= w_a_mag;
      r_dvs    <= w_b_mag;
      r_cnt    <= 6'd0;
      r_sign_q <= A[31] ^ B[31];
      r_sign_r <= A[31];
    end else if (w_iter) begin
      r_rem <= w_rem_nxt;
      r_dq  <= w_dq_nxt;
      r_cnt <= r_cnt + 6'd1;
    end
  end

  // Sign fix-up uses the final iteration's values so results land on the edge leaving RUN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi       <= 32'd0;
      lo       <= 32'd0;
      div_stop <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      div_stop <= w_finish | w_zero_path;
      div_zero <= w_zero_path;
      if (w_finish) begin
        lo <= r_sign_q ? (32'd0 - w_dq_nxt) : w_dq_nxt;
        hi <= r_sign_r ? (32'd0 - w_rem_nxt) : w_rem_nxt;
      end
    end
  end

endmodule

// File: tb/tb_div.sv
// Directed self-checking bench for the sequential signed divider.
module tb_div;

  logic        clk;
  logic        reset;
  logic        div_control;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_stop;
  logic        div_zero;

  int total = 0;
  int bad   = 0;

  div dut (
    .clk        (clk),
    .reset      (reset),
    .div_control(div_control),
    .A          (A),
    .B          (B),
    .hi         (hi),
    .lo         (lo),
    .div_stop   (div_stop),
    .div_zero   (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [31:0] a, input logic [31:0] b);
    A           = a;
    B           = b;
    div_control = 1'b1;
    tick();
    div_control = 1'b0;
  endtask

  // Ticks until div_stop is seen; n is ticks taken, or budget+1 on timeout.
  task automatic wait_stop(input int budget, output int n);
    n = 0;
    while (!div_stop && n <= budget) begin
      tick();
      n++;
    end
  endtask

  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_lo, input logic [31:0] exp_hi);
    int n;
    start(a, b);
    wait_stop(40, n);
    check({tag, " latency"}, n, 32);
    check({tag, " lo"}, lo, exp_lo);
    check({tag, " hi"}, hi, exp_hi);
    check({tag, " zero"}, {31'd0, div_zero}, 32'd0);
    tick();
    check({tag, " stop1cyc"}, {31'd0, div_stop}, 32'd0);
  endtask

  initial begin
    int n;
    int seen;
    reset       = 1'b1;
    div_control = 1'b0;
    A           = 32'd0;
    B           = 32'd0;
    #12;
    check("rst hi", hi, 32'd0);
    check("rst lo", lo, 32'd0);
    check("rst stop", {31'd0, div_stop}, 32'd0);
    check("rst zero", {31'd0, div_zero}, 32'd0);
    reset = 1'b0;
    tick();

    run_div("7/2", 32'd7, 32'd2, 32'd3, 32'd1);

    // Zero divisor: flags next cycle, previous result kept.
    start(32'd5, 32'd0);
    check("z stop", {31'd0, div_stop}, 32'd1);
    check("z zero", {31'd0, div_zero}, 32'd1);
    check("z hi", hi, 32'd1);
    check("z lo", lo, 32'd3);
    tick();
    check("z stop off", {31'd0, div_stop}, 32'd0);
    check("z zero off", {31'd0, div_zero}, 32'd0);

    run_div("-7/2", 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_div("7/-2", 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
    run_div("min/-1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
    run_div("min/1", 32'h8000_0000, 32'd1, 32'h8000_0000, 32'd0);
    run_div("-100/-7", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE);
    run_div("3/min", 32'd3, 32'h8000_0000, 32'd0, 32'd3);

    // Mid-run input changes and a second start are ignored.
    start(32'd100, 32'd7);
    repeat (9) tick();
    check("busy hi", hi, 32'd3);
    check("busy lo", lo, 32'd0);
    A           = 32'd1;
    B           = 32'd1;
    div_control = 1'b1;
    tick();
    div_control = 1'b0;
    wait_stop(40, n);
    check("ign latency", n + 10, 32);
    check("ign lo", lo, 32'd14);
    check("ign hi", hi, 32'd2);
    tick();

    // Reset in the middle of a run aborts it with no stop pulse.
    start(32'd100, 32'd7);
    repeat (14) tick();
    #2;
    reset = 1'b1;
    #1;
    check("abort hi", hi, 32'd0);
    check("abort lo", lo, 32'd0);
    check("abort stop", {31'd0, div_stop}, 32'd0);
    tick();
    reset = 1'b0;
    seen  = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (div_stop) seen++;
    end
    check("abort nostop", seen, 0);
    run_div("9/3", 32'd9, 32'd3, 32'd3, 32'd0);

    // Held start with zero divisor retriggers every 2 cycles.
    A           = 32'd1;
    B           = 32'd0;
    div_control = 1'b1;
    seen        = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (div_stop && div_zero) seen++;
    end
    div_control = 1'b0;
    check("b2b zero", seen, 4);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
